if_pc_ctrl: RTL and testbench

- Program-counter controller for the IF stage of the MIPS pipeline.
- Holds the PC register and drives the select of the 2:1 next-PC mux: sequential PC+PC_STEP versus redirect target.
- Sequences fetch under debug-unit control: continuous run or single-step. Also handles hazard stalls, branch/jump redirects with IF/ID flush, and HALT detection.
- Sits between the debug unit, the hazard unit, ID/EX redirect logic and the instruction memory address port.

---
 rtl/if_pc_ctrl.sv | 129 ++++++++++++
 tb/tb_if_pc_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_ctrl.sv
// if_pc_ctrl -- program-counter controller for the IF stage.
//
// Holds the PC register and drives the select of the external 2:1 next-PC
// mux (sequential PC+PC_STEP vs. branch/jump target). Fetch is sequenced
// under debug-unit control (continuous run or single-step). The controller
// also honours hazard stalls, applies branch/jump redirects with an IF/ID
// flush, and stops in HALT when a HALT opcode is fetched.
//
// Ports:
//   i_clk, i_reset_n    clock (rising edge), asynchronous active-low reset
//   i_start, i_mode     debug start/restart pulse; mode 0=run, 1=single-step
//   i_step              single-step pulse (one fetch per asserted cycle)
//   i_stall             load-use stall from the hazard unit
//   i_branch_taken/_target, i_jump/_target   redirect requests and targets
//   i_halt_decoded      HALT opcode present in the fetched instruction
//   o_pc, o_pc_seq      current PC and PC+PC_STEP (mux input A)
//   o_redirect_target   branch target (priority) or jump target (mux input B)
//   o_mux_sel           0=sequential, 1=redirect
//   o_pc_enable         PC / IF-ID write enable
//   o_flush             IF/ID flush
//   o_state, o_halted   FSM state, HALT indicator
//   o_cycle_cnt         saturating count of active cycles
module if_pc_ctrl #(
    parameter int unsigned                   SIZE_REG_MEM = 32,
    parameter int unsigned                   PC_STEP      = 4,
    parameter logic [SIZE_REG_MEM-1:0]       RESET_PC     = '0,
    parameter int unsigned                   CNT_WIDTH    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic                    i_step,
    input  logic                    i_stall,
    input  logic                    i_branch_taken,
    input  logic [SIZE_REG_MEM-1:0] i_branch_target,
    input  logic                    i_jump,
    input  logic [SIZE_REG_MEM-1:0] i_jump_target,
    input  logic                    i_halt_decoded,
    output logic [SIZE_REG_MEM-1:0] o_pc,
    output logic [SIZE_REG_MEM-1:0] o_pc_seq,
    output logic [SIZE_REG_MEM-1:0] o_redirect_target,
    output logic                    o_mux_sel,
    output logic                    o_pc_enable,
    output logic                    o_flush,
    output logic [1:0]              o_state,
    output logic                    o_halted,
    output logic [CNT_WIDTH-1:0]    o_cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t                  state, state_next;
    logic [SIZE_REG_MEM-1:0] pc_q, pc_next;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_next;

    logic active;
    logic redirect;
    logic advance;
    logic halt_cond;

    // Datapath toward the next-PC mux
    assign o_pc_seq          = pc_q + SIZE_REG_MEM'(PC_STEP);
    assign o_redirect_target = i_branch_taken ? i_branch_target : i_jump_target;
    assign o_mux_sel         = i_branch_taken | i_jump;

    // A redirect comes from an older instruction than the stalled one, so
    // it overrides the stall.
    assign active    = (state == RUN) | ((state == STEP) & i_step);
    assign redirect  = active & (i_branch_taken | i_jump);
    assign advance   = active & (redirect | ~i_stall);
    // A redirect flushes the fetched HALT, so HALT only counts without one.
    assign halt_cond = advance & i_halt_decoded & ~redirect;

    assign o_pc_enable = advance;
    assign o_flush     = redirect;
    assign o_pc        = pc_q;
    assign o_state     = state;
    assign o_halted    = (state == HALT);
    assign o_cycle_cnt = cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            cnt_q <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        cnt_next   = cnt_q;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = i_mode ? STEP : RUN;
                    cnt_next   = '0;
                end
            end
            RUN, STEP: begin
                // Stalled cycles still count; only advancing ones move the PC
                if (active && (cnt_q != '1))
                    cnt_next = cnt_q + 1'b1;
                if (halt_cond)
                    state_next = HALT;
                else if (advance)
                    pc_next = redirect ? o_redirect_target : o_pc_seq;
            end
            HALT: begin
                if (i_start) begin
                    state_next = IDLE;
                    pc_next    = RESET_PC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
module tb_if_pc_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0, i_mode = 1'b0, i_step = 1'b0, i_stall = 1'b0;
    logic        i_branch_taken = 1'b0, i_jump = 1'b0, i_halt_decoded = 1'b0;
    logic [31:0] i_branch_target = '0, i_jump_target = '0;

    logic [31:0] o_pc, o_pc_seq, o_redirect_target, o_cycle_cnt;
    logic        o_mux_sel, o_pc_enable, o_flush, o_halted;
    logic [1:0]  o_state;

    logic [31:0] w_pc, w_pc_seq, w_redirect_target, w_cycle_cnt;
    logic        w_mux_sel, w_pc_enable, w_flush, w_halted;
    logic [1:0]  w_state;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 i_clk = ~i_clk;

    if_pc_ctrl dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_mode(i_mode),
        .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
        .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
        .i_halt_decoded(i_halt_decoded), .o_pc(o_pc), .o_pc_seq(o_pc_seq),
        .o_redirect_target(o_redirect_target), .o_mux_sel(o_mux_sel),
        .o_pc_enable(o_pc_enable), .o_flush(o_flush), .o_state(o_state),
        .o_halted(o_halted), .o_cycle_cnt(o_cycle_cnt)
    );

    if_pc_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_mode(i_mode),
        .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
        .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
        .i_halt_decoded(i_halt_decoded), .o_pc(w_pc), .o_pc_seq(w_pc_seq),
        .o_redirect_target(w_redirect_target), .o_mux_sel(w_mux_sel),
        .o_pc_enable(w_pc_enable), .o_flush(w_flush), .o_state(w_state),
        .o_halted(w_halted), .o_cycle_cnt(w_cycle_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the main DUT: mode 0=idle 1=run 2=step 3=halt
    int          m_mode = 0;
    bit [31:0]   m_pc = 0;
    bit [31:0]   m_cnt = 0;

    function automatic bit m_fetching();
        return (m_mode == 1) || (m_mode == 2 && i_step);
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_mode = 0;
            m_pc   = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            if (i_start) begin
                m_mode = i_mode ? 2 : 1;
                m_cnt  = 0;
            end
        end else if (m_mode == 3) begin
            if (i_start) begin
                m_mode = 0;
                m_pc   = 0;
            end
        end else if (m_fetching()) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (i_branch_taken)      m_pc = i_branch_target;
            else if (i_jump)         m_pc = i_jump_target;
            else if (!i_stall) begin
                if (i_halt_decoded)  m_mode = 3;
                else                 m_pc = m_pc + 4;
            end
        end
    end

    // Per-cycle comparison, mid-cycle while inputs are stable
    always @(negedge i_clk) begin
        if (chk_en) begin
            bit rq;
            rq = m_fetching() && (i_branch_taken || i_jump);
            check("pc", o_pc, m_pc);
            check("pc_seq", o_pc_seq, m_pc + 32'd4);
            check("redirect_target", o_redirect_target,
                  i_branch_taken ? i_branch_target : i_jump_target);
            check("mux_sel", o_mux_sel, i_branch_taken || i_jump);
            check("flush", o_flush, rq);
            check("pc_enable", o_pc_enable, m_fetching() && (rq || !i_stall));
            check("state", o_state, m_mode[1:0]);
            check("halted", o_halted, m_mode == 3);
            check("cycle_cnt", o_cycle_cnt, m_cnt);
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        i_start = 0; i_mode = 0; i_step = 0; i_stall = 0;
        i_branch_taken = 0; i_jump = 0; i_halt_decoded = 0;
        i_branch_target = '0; i_jump_target = '0;
    endtask

    initial begin
        // Reset
        tick(2);
        check("reset_pc", o_pc, 32'h0);
        check("reset_state", o_state, 2'b00);
        check("reset_en", {o_pc_enable, o_flush, o_halted, o_mux_sel}, 4'b0);
        check("reset_pc_w", w_pc, 32'hFFFF_FFF8);
        i_reset_n = 1;
        chk_en = 1;
        tick(1);

        // Continuous run: 0,4,...,20
        i_start = 1; i_mode = 0;
        tick(1);
        idle_inputs();
        check("run_start_pc", o_pc, 32'h0);
        tick(5);
        check("run_pc", o_pc, 32'd20);
        check("run_state", o_state, 2'b01);
        check("run_cnt", o_cycle_cnt, 32'd5);
        check("run_mux_sel", o_mux_sel, 1'b0);

        // Jump to 0x10, stall 2, branch to 0x40 while stalled
        i_jump = 1; i_jump_target = 32'h10;
        tick(1);
        idle_inputs();
        i_stall = 1;
        tick(2);
        check("stall_hold", o_pc, 32'h10);
        i_branch_taken = 1; i_branch_target = 32'h40;
        #3;
        check("br_flush", o_flush, 1'b1);
        check("br_mux_sel", o_mux_sel, 1'b1);
        tick(1);
        check("br_pc", o_pc, 32'h40);
        // Branch and jump together: branch wins
        i_stall = 0; i_branch_taken = 1; i_branch_target = 32'h40;
        i_jump = 1; i_jump_target = 32'h80;
        tick(1);
        idle_inputs();
        check("br_prio_pc", o_pc, 32'h40);

        // HALT at 0x20
        i_jump = 1; i_jump_target = 32'h20;
        tick(1);
        idle_inputs();
        i_halt_decoded = 1;
        tick(1);
        idle_inputs();
        tick(10);
        check("halt_flag", o_halted, 1'b1);
        check("halt_pc", o_pc, 32'h20);
        check("halt_en", o_pc_enable, 1'b0);
        i_start = 1;
        tick(1);
        idle_inputs();
        check("restart_state", o_state, 2'b00);
        check("restart_pc", o_pc, 32'h0);
        // HALT coinciding with a branch is squashed
        i_start = 1;
        tick(1);
        idle_inputs();
        i_halt_decoded = 1; i_branch_taken = 1; i_branch_target = 32'h8;
        tick(1);
        idle_inputs();
        check("halt_sq_pc", o_pc, 32'h8);
        check("halt_sq_state", o_state, 2'b01);

        // Single-step mode
        i_reset_n = 0;
        #2;
        i_reset_n = 1;
        tick(1);
        i_start = 1; i_mode = 1;
        tick(1);
        idle_inputs();
        for (int s = 0; s < 3; s++) begin
            tick(2);
            i_step = 1;
            tick(1);
            i_step = 0;
            tick(2);
        end
        check("step_pc", o_pc, 32'd12);
        check("step_cnt", o_cycle_cnt, 32'd3);
        check("step_state", o_state, 2'b10);
        i_step = 1; i_stall = 1;
        tick(1);
        idle_inputs();
        check("step_stall_pc", o_pc, 32'd12);
        check("step_stall_cnt", o_cycle_cnt, 32'd4);
        i_step = 1; i_halt_decoded = 1;
        tick(1);
        idle_inputs();
        check("step_halt", o_state, 2'b11);

        // Wrap-around on the RESET_PC=FFFFFFF8 instance
        i_reset_n = 0;
        #2;
        i_reset_n = 1;
        tick(1);
        i_start = 1;
        tick(1);
        idle_inputs();
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        tick(1);
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        tick(1);
        check("wrap_pc2", w_pc, 32'h0000_0000);
        tick(1);
        check("wrap_pc3", w_pc, 32'h0000_0004);
        check("wrap_state", w_state, 2'b01);
        // Asynchronous reset mid-cycle
        #1;
        i_reset_n = 0;
        #1;
        check("async_pc_w", w_pc, 32'hFFFF_FFF8);
        check("async_state_w", w_state, 2'b00);
        check("async_pc", o_pc, 32'h0);
        check("async_state", o_state, 2'b00);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
